// File: rtl/seq_array_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : seq_array_multiplier
// Description : Iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
//               Per-operation signed (two's-complement) or unsigned mode.
//               Valid/ready handshake on input and output. One partial
//               product is accumulated per clock. Latency and throughput are
//               fixed and do not depend on the operand values.
// Ports       : clk        - clock, rising edge
//               rst        - synchronous active-high reset
//               in_valid   - operands/mode valid
//               in_ready   - block idle and able to accept operands
//               in_m       - multiplicand
//               in_q       - multiplier
//               in_signed  - 1 = two's-complement operands, 0 = unsigned
//               out_valid  - product valid
//               out_ready  - consumer accepts product
//               out_p      - product, 2*WIDTH bits
//               busy       - an operation is in progress
// Revision    : 1.0 - initial release
// ============================================================================
module seq_array_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_m,
    input  logic [WIDTH-1:0]   in_q,
    input  logic               in_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic               busy
);

    localparam int               c_CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [2*WIDTH-1:0] r_mcand;   // |m| shifted left by the iteration count
    logic [WIDTH-1:0]   r_mplier;  // |q| shifted right; bit 0 is the bit under test
    logic [2*WIDTH-1:0] r_acc;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_neg;
    logic [2*WIDTH-1:0] r_prod;

    logic               w_accept;
    logic [WIDTH-1:0]   w_m_mag;
    logic [WIDTH-1:0]   w_q_mag;
    logic [2*WIDTH-1:0] w_acc_next;

    assign w_accept = in_valid && (r_state == S_IDLE);

    // Magnitude of the most-negative value wraps to 2^(WIDTH-1), which is
    // exactly right when the result is read as an unsigned WIDTH-bit value.
    assign w_m_mag = (in_signed && in_m[WIDTH-1]) ? (-in_m) : in_m;
    assign w_q_mag = (in_signed && in_q[WIDTH-1]) ? (-in_q) : in_q;

    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (in_valid)          w_state_next = S_RUN;
            S_RUN:  if (r_cnt == c_LAST)   w_state_next = S_FIX;
            S_FIX:                         w_state_next = S_DONE;
            S_DONE: if (out_ready)         w_state_next = S_IDLE;
            default:                       w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_prod   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_m_mag};
                        r_mplier <= w_q_mag;
                        r_neg    <= in_signed && (in_m[WIDTH-1] ^ in_q[WIDTH-1]);
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                S_RUN: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= (r_cnt == c_LAST) ? '0 : r_cnt + 1'b1;
                end
                S_FIX: begin
                    // Negating zero yields zero, so no -0 special case.
                    r_prod <= r_neg ? (-r_acc) : r_acc;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign out_p     = r_prod;

endmodule
`default_nettype wire

// File: tb/tb_seq_array_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_array_multiplier
// Description : Self-checking bench for seq_array_multiplier. Exercises a
//               WIDTH=4 instance with a directed vector table, backpressure,
//               and a WIDTH=8 instance with mid-operation reset and a
//               back-to-back random stream checked against a golden model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_array_multiplier;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // WIDTH = 4 instance
    logic       in_valid4, in_ready4, s4, out_valid4, out_ready4, busy4;
    logic [3:0] m4, q4;
    logic [7:0] p4;

    // WIDTH = 8 instance
    logic        in_valid8, in_ready8, s8, out_valid8, out_ready8, busy8;
    logic [7:0]  m8, q8;
    logic [15:0] p8;

    seq_array_multiplier #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .in_m(m4), .in_q(q4), .in_signed(s4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .out_p(p4), .busy(busy4)
    );

    seq_array_multiplier #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .in_m(m8), .in_q(q8), .in_signed(s8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .out_p(p8), .busy(busy8)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0] m;
        logic [3:0] q;
        logic       s;
        logic [7:0] p;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] golden8(input logic [7:0] m, input logic [7:0] q, input logic s);
        logic signed [8:0]  a;
        logic signed [8:0]  b;
        logic signed [17:0] p;
        a = s ? {m[7], m} : {1'b0, m};
        b = s ? {q[7], q} : {1'b0, q};
        p = a * b;
        return p[15:0];
    endfunction

    // One full WIDTH=4 operation with out_ready held high.
    task automatic op4(input logic [3:0] m, input logic [3:0] q, input logic s,
                       input logic [7:0] exp, input string name);
        int   n;
        logic bad;
        @(negedge clk);
        check({name, " in_ready before"}, 32'(in_ready4), 32'd1);
        in_valid4 = 1'b1; m4 = m; q4 = q; s4 = s;
        @(negedge clk);
        in_valid4 = 1'b0;
        n = 0; bad = 1'b0;
        while (!out_valid4 && n < 20) begin
            if (in_ready4 || !busy4) bad = 1'b1;
            @(negedge clk);
            n++;
        end
        check({name, " latency"}, 32'(n), 32'd5);
        check({name, " busy/in_ready while running"}, 32'(bad), 32'd0);
        check({name, " product"}, 32'(p4), 32'(exp));
        @(negedge clk);
        check({name, " back to idle"}, {30'd0, out_valid4, in_ready4}, 32'b01);
    endtask

    // One full WIDTH=8 operation with out_ready held high.
    task automatic op8(input logic [7:0] m, input logic [7:0] q, input logic s,
                       input logic [15:0] exp, input string name);
        int n;
        @(negedge clk);
        in_valid8 = 1'b1; m8 = m; q8 = q; s8 = s;
        @(negedge clk);
        in_valid8 = 1'b0;
        n = 0;
        while (!out_valid8 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check({name, " latency"}, 32'(n), 32'd9);
        check({name, " product"}, 32'(p8), 32'(exp));
        @(negedge clk);
    endtask

    task automatic rnd8();
        m8 = 8'($urandom);
        q8 = 8'($urandom);
        s8 = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) m8 = 8'h80;
        if ($urandom_range(0, 9) == 0) q8 = 8'h00;
        if ($urandom_range(0, 9) == 0) q8 = 8'h80;
    endtask

    vec_t vecs[10];

    initial begin
        logic        stable;
        logic        acc;
        int          n;
        int          cyc, last_acc, last_out, n_acc, n_out;
        logic [15:0] expq[$];
        logic [15:0] e;

        // Hand-computed WIDTH=4 vectors: {m, q, signed, product}
        vecs[0] = '{4'hF, 4'hF, 1'b0, 8'hE1};  // 15*15 = 225
        vecs[1] = '{4'h8, 4'h8, 1'b1, 8'h40};  // -8*-8 = 64
        vecs[2] = '{4'h8, 4'h7, 1'b1, 8'hC8};  // -8*7 = -56
        vecs[3] = '{4'h3, 4'hF, 1'b1, 8'hFD};  // 3*-1 = -3
        vecs[4] = '{4'h0, 4'hB, 1'b1, 8'h00};  // 0*-5 = 0
        vecs[5] = '{4'h9, 4'hA, 1'b0, 8'h5A};  // 9*10 = 90
        vecs[6] = '{4'h7, 4'h7, 1'b1, 8'h31};  // 7*7 = 49
        vecs[7] = '{4'hF, 4'hF, 1'b1, 8'h01};  // -1*-1 = 1
        vecs[8] = '{4'hF, 4'h8, 1'b0, 8'h78};  // 15*8 = 120
        vecs[9] = '{4'h8, 4'h1, 1'b1, 8'hF8};  // -8*1 = -8

        rst = 1'b1;
        in_valid4 = 1'b0; m4 = '0; q4 = '0; s4 = 1'b0; out_ready4 = 1'b1;
        in_valid8 = 1'b0; m8 = '0; q8 = '0; s8 = 1'b0; out_ready8 = 1'b1;
        repeat (3) @(negedge clk);

        check("reset dut4 flags", {29'd0, in_ready4, out_valid4, busy4}, 32'b100);
        check("reset dut4 out_p", 32'(p4), 32'd0);
        check("reset dut8 flags", {29'd0, in_ready8, out_valid8, busy8}, 32'b100);
        check("reset dut8 out_p", 32'(p8), 32'd0);
        rst = 1'b0;

        // Idle with in_valid low stays idle.
        repeat (3) @(negedge clk);
        check("idle hold", {30'd0, in_ready4, busy4}, 32'b10);

        for (int i = 0; i < 10; i++) begin
            op4(vecs[i].m, vecs[i].q, vecs[i].s, vecs[i].p, $sformatf("vec%0d", i));
        end

        // Backpressure: 6*7 held in DONE while new operands are pulsed.
        out_ready4 = 1'b0;
        @(negedge clk);
        in_valid4 = 1'b1; m4 = 4'd6; q4 = 4'd7; s4 = 1'b0;
        @(negedge clk);
        in_valid4 = 1'b0;
        n = 0;
        while (!out_valid4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp latency", 32'(n), 32'd5);
        check("bp product", 32'(p4), 32'd42);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid4 = i[0];
            m4 = 4'($urandom); q4 = 4'($urandom); s4 = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (!out_valid4 || p4 != 8'd42 || in_ready4 || !busy4) stable = 1'b0;
        end
        check("bp held stable", 32'(stable), 32'd1);
        in_valid4 = 1'b0;
        out_ready4 = 1'b1;
        @(negedge clk);
        check("bp release flags", {29'd0, in_ready4, out_valid4, busy4}, 32'b100);
        check("bp release out_p kept", 32'(p4), 32'd42);

        // Reset mid-operation on the WIDTH=8 instance.
        @(negedge clk);
        in_valid8 = 1'b1; m8 = 8'd200; q8 = 8'd200; s8 = 1'b0;
        @(negedge clk);
        in_valid8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst flags", {29'd0, in_ready8, out_valid8, busy8}, 32'b100);
        check("midrst out_p", 32'(p8), 32'd0);
        op8(8'd12, 8'd13, 1'b0, 16'd156, "after reset 12*13");
        op8(8'h80, 8'h80, 1'b1, 16'h4000, "w8 -128*-128");
        op8(8'h80, 8'h7F, 1'b1, 16'hC080, "w8 -128*127");

        // Back-to-back stream: in_valid and out_ready held high.
        cyc = 0; last_acc = -1; last_out = -1; n_acc = 0; n_out = 0;
        in_valid8 = 1'b1;
        rnd8();
        while (n_out < 1000 && cyc < 13000) begin
            if (out_valid8) begin
                if (expq.size() == 0) begin
                    check("stream unexpected output", 32'(p8), 32'hFFFF_FFFF);
                end else begin
                    e = expq.pop_front();
                    check($sformatf("stream product %0d", n_out), 32'(p8), 32'(e));
                end
                if (last_out >= 0) check("stream output spacing", 32'(cyc - last_out), 32'd11);
                last_out = cyc;
                n_out++;
            end
            acc = in_valid8 && in_ready8;
            if (acc) begin
                expq.push_back(golden8(m8, q8, s8));
                if (last_acc >= 0) check("stream initiation interval", 32'(cyc - last_acc), 32'd11);
                last_acc = cyc;
                n_acc++;
            end
            @(negedge clk);
            cyc++;
            if (acc) begin
                if (n_acc == 1000) in_valid8 = 1'b0;
                else               rnd8();
            end
        end
        check("stream accepted count", 32'(n_acc), 32'd1000);
        check("stream output count", 32'(n_out), 32'd1000);
        check("stream leftover", 32'(expq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
